// File: rtl/game_collision_scheduler.sv
// Time-multiplexed collision scheduler: one box-overlap comparator walks every
// bullet/enemy/player pair of a frame, one pair per clock, and publishes
// sticky per-slot hit flags at the end of the scan.
module game_collision_scheduler #(
   parameter int unsigned MAX_ENEMY         = 4,
   parameter int unsigned MAX_ENEMY_BULLET  = 8,
   parameter int unsigned MAX_PLAYER_BULLET = 4,
   parameter int unsigned BULLET_WIDTH      = 4,
   parameter int unsigned BULLET_HEIGHT     = 8,
   parameter int unsigned ENEMY_WIDTH       = 32,
   parameter int unsigned ENEMY_HEIGHT      = 24,
   parameter int unsigned PLAYER_WIDTH      = 32,
   parameter int unsigned PLAYER_HEIGHT     = 24,
   parameter int unsigned PLAYER_CENTER_Y   = 440
) (
   input  logic                            i_Clk,
   input  logic                            i_Rst,
   input  logic                            i_Start,
   input  logic [19*MAX_ENEMY_BULLET-1:0]  c_EnemyBulletPosition,
   input  logic [19*MAX_PLAYER_BULLET-1:0] c_PlayerBulletPosition,
   input  logic [19*MAX_ENEMY-1:0]         c_EnemyPosition,
   input  logic [9:0]                      c_PlayerPosition,
   input  logic [MAX_ENEMY_BULLET-1:0]     i_EnemyBulletValid,
   input  logic [MAX_PLAYER_BULLET-1:0]    i_PlayerBulletValid,
   input  logic [MAX_ENEMY-1:0]            i_EnemyValid,
   output logic                            o_Busy,
   output logic                            o_Done,
   output logic [MAX_ENEMY_BULLET-1:0]     o_EnemyBulletHit,
   output logic [MAX_PLAYER_BULLET-1:0]    o_PlayerBulletHit,
   output logic [MAX_ENEMY-1:0]            o_EnemyHit,
   output logic                            o_PlayerHit
);

   localparam int unsigned MaxSlots = (MAX_ENEMY_BULLET > MAX_PLAYER_BULLET) ?
      ((MAX_ENEMY_BULLET > MAX_ENEMY) ? MAX_ENEMY_BULLET : MAX_ENEMY) :
      ((MAX_PLAYER_BULLET > MAX_ENEMY) ? MAX_PLAYER_BULLET : MAX_ENEMY);
   localparam int unsigned IdxW = (MaxSlots > 1) ? $clog2(MaxSlots) : 1;

   typedef enum logic [2:0] {StIdle, StEbPb, StPbEn, StEbPl, StDone} state_e;

   state_e                       state_q, state_d;
   logic [IdxW-1:0]              a_q, a_d, b_q, b_d;
   logic [MAX_ENEMY_BULLET-1:0]  eb_hit_q, eb_hit_d;
   logic [MAX_PLAYER_BULLET-1:0] pb_hit_q, pb_hit_d;
   logic [MAX_ENEMY-1:0]         en_hit_q, en_hit_d;
   logic                         pl_hit_q, pl_hit_d;
   logic                         done_q;

   // Slot fetch: outer index a and inner index b select positions, valids, one-hots
   logic [18:0]                  eb_a_pos, pb_a_pos, pb_b_pos, en_b_pos;
   logic                         eb_a_v, pb_a_v, pb_b_v, en_b_v;
   logic [MAX_ENEMY_BULLET-1:0]  eb_a_sel;
   logic [MAX_PLAYER_BULLET-1:0] pb_a_sel, pb_b_sel;
   logic [MAX_ENEMY-1:0]         en_b_sel;

   // Decode the current slot indices into positions, valids and one-hot selects
   always_comb begin
      eb_a_pos = '0; eb_a_v = 1'b0; eb_a_sel = '0;
      pb_a_pos = '0; pb_a_v = 1'b0; pb_a_sel = '0;
      pb_b_pos = '0; pb_b_v = 1'b0; pb_b_sel = '0;
      en_b_pos = '0; en_b_v = 1'b0; en_b_sel = '0;
      for (int k = 0; k < int'(MAX_ENEMY_BULLET); k++) begin
         if (a_q == IdxW'(k)) begin
            eb_a_pos    = c_EnemyBulletPosition[19*k +: 19];
            eb_a_v      = i_EnemyBulletValid[k];
            eb_a_sel[k] = 1'b1;
         end
      end
      for (int k = 0; k < int'(MAX_PLAYER_BULLET); k++) begin
         if (a_q == IdxW'(k)) begin
            pb_a_pos    = c_PlayerBulletPosition[19*k +: 19];
            pb_a_v      = i_PlayerBulletValid[k];
            pb_a_sel[k] = 1'b1;
         end
         if (b_q == IdxW'(k)) begin
            pb_b_pos    = c_PlayerBulletPosition[19*k +: 19];
            pb_b_v      = i_PlayerBulletValid[k];
            pb_b_sel[k] = 1'b1;
         end
      end
      for (int k = 0; k < int'(MAX_ENEMY); k++) begin
         if (b_q == IdxW'(k)) begin
            en_b_pos    = c_EnemyPosition[19*k +: 19];
            en_b_v      = i_EnemyValid[k];
            en_b_sel[k] = 1'b1;
         end
      end
   end

   // Shared comparator: route the pair for the current phase into boxes A and B
   logic [9:0]  ax, bx;
   logic [8:0]  ay, by;
   logic [10:0] aw, bw, ax_end, bx_end;
   logic [9:0]  ah, bh, ay_end, by_end;
   logic        pair_v, overlap;

   always_comb begin
      ax = '0; ay = '0; aw = '0; ah = '0;
      bx = '0; by = '0; bw = '0; bh = '0;
      pair_v = 1'b0;
      unique case (state_q)
         StEbPb: begin
            {ax, ay} = eb_a_pos; aw = 11'(BULLET_WIDTH); ah = 10'(BULLET_HEIGHT);
            {bx, by} = pb_b_pos; bw = 11'(BULLET_WIDTH); bh = 10'(BULLET_HEIGHT);
            pair_v   = eb_a_v & pb_b_v;
         end
         StPbEn: begin
            {ax, ay} = pb_a_pos; aw = 11'(BULLET_WIDTH); ah = 10'(BULLET_HEIGHT);
            {bx, by} = en_b_pos; bw = 11'(ENEMY_WIDTH);  bh = 10'(ENEMY_HEIGHT);
            pair_v   = pb_a_v & en_b_v;
         end
         StEbPl: begin
            {ax, ay} = eb_a_pos; aw = 11'(BULLET_WIDTH); ah = 10'(BULLET_HEIGHT);
            bx       = c_PlayerPosition; by = 9'(PLAYER_CENTER_Y);
            bw       = 11'(PLAYER_WIDTH); bh = 10'(PLAYER_HEIGHT);
            pair_v   = eb_a_v;
         end
         default: pair_v = 1'b0;
      endcase
      // Far edges computed one bit wider so boxes near the screen edge never wrap
      ax_end  = {1'b0, ax} + aw;
      bx_end  = {1'b0, bx} + bw;
      ay_end  = {1'b0, ay} + ah;
      by_end  = {1'b0, by} + bh;
      overlap = pair_v &&
                !(ax_end <= {1'b0, bx} || {1'b0, ax} >= bx_end) &&
                !(ay_end <= {1'b0, by} || {1'b0, ay} >= by_end);
   end

   // Scan sequencing: b is the inner index, a the outer; flags accumulate by OR
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      eb_hit_d = eb_hit_q;
      pb_hit_d = pb_hit_q;
      en_hit_d = en_hit_q;
      pl_hit_d = pl_hit_q;
      unique case (state_q)
         StIdle: begin
            if (i_Start) begin
               state_d  = StEbPb;
               a_d      = '0;
               b_d      = '0;
               eb_hit_d = '0;
               pb_hit_d = '0;
               en_hit_d = '0;
               pl_hit_d = 1'b0;
            end
         end
         StEbPb: begin
            if (overlap) begin
               eb_hit_d = eb_hit_q | eb_a_sel;
               pb_hit_d = pb_hit_q | pb_b_sel;
            end
            if (b_q == IdxW'(MAX_PLAYER_BULLET - 1)) begin
               b_d = '0;
               if (a_q == IdxW'(MAX_ENEMY_BULLET - 1)) begin
                  a_d     = '0;
                  state_d = StPbEn;
               end else begin
                  a_d = a_q + 1'b1;
               end
            end else begin
               b_d = b_q + 1'b1;
            end
         end
         StPbEn: begin
            if (overlap) begin
               pb_hit_d = pb_hit_q | pb_a_sel;
               en_hit_d = en_hit_q | en_b_sel;
            end
            if (b_q == IdxW'(MAX_ENEMY - 1)) begin
               b_d = '0;
               if (a_q == IdxW'(MAX_PLAYER_BULLET - 1)) begin
                  a_d     = '0;
                  state_d = StEbPl;
               end else begin
                  a_d = a_q + 1'b1;
               end
            end else begin
               b_d = b_q + 1'b1;
            end
         end
         StEbPl: begin
            if (overlap) begin
               eb_hit_d = eb_hit_q | eb_a_sel;
               pl_hit_d = 1'b1;
            end
            if (a_q == IdxW'(MAX_ENEMY_BULLET - 1)) begin
               a_d     = '0;
               state_d = StDone;
            end else begin
               a_d = a_q + 1'b1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State, indices and working flags
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         eb_hit_q <= '0;
         pb_hit_q <= '0;
         en_hit_q <= '0;
         pl_hit_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         eb_hit_q <= eb_hit_d;
         pb_hit_q <= pb_hit_d;
         en_hit_q <= en_hit_d;
         pl_hit_q <= pl_hit_d;
      end
   end

   // Published results change only on the edge leaving DONE, with a one-cycle strobe
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         done_q            <= 1'b0;
         o_EnemyBulletHit  <= '0;
         o_PlayerBulletHit <= '0;
         o_EnemyHit        <= '0;
         o_PlayerHit       <= 1'b0;
      end else begin
         done_q <= (state_q == StDone);
         if (state_q == StDone) begin
            o_EnemyBulletHit  <= eb_hit_q;
            o_PlayerBulletHit <= pb_hit_q;
            o_EnemyHit        <= en_hit_q;
            o_PlayerHit       <= pl_hit_q;
         end
      end
   end

   assign o_Done = done_q;
   assign o_Busy = (state_q == StEbPb) || (state_q == StPbEn) || (state_q == StEbPl);

endmodule
